// File: rtl/fifo_reader_pkg.sv
// Shared types and default sizes for the fifo_reader burst engine.
package fifo_reader_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        FLUSH,
        DONE
    } rd_state_t;

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry output buffer holding {data, last} between the FIFO pop and the stream.
module fifo_reader_skid
    import fifo_reader_pkg::*;
#(
    parameter int width = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             push_last,
    input  logic             accept,
    output logic [1:0]       occ,
    output logic [width-1:0] head_data,
    output logic             head_last
);

    logic [width:0] mem [2];
    logic           wr_ptr;
    logic           rd_ptr;
    logic           do_push;
    logic           do_accept;

    assign do_push   = push && (occ != 2'd2);
    assign do_accept = accept && (occ != 2'd0);

    // Entries are cleared on reset so the stream head reads back as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= {push_data, push_last};
                wr_ptr      <= ~wr_ptr;
            end
            if (do_accept) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_accept})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign {head_data, head_last} = mem[rd_ptr];

endmodule

// File: rtl/fifo_reader.sv
// Burst read engine: pops a programmed number of words from a FWFT FIFO onto a valid/ready stream.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int width = DEF_WIDTH,
    parameter int cnt_w = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [cnt_w-1:0] len,
    output logic             busy,
    output logic             done,
    input  logic             pndng,
    input  logic [width-1:0] dato_out,
    output logic             pop,
    output logic             m_valid,
    output logic [width-1:0] m_data,
    output logic             m_last,
    input  logic             m_ready,
    output logic [cnt_w-1:0] rd_count
);

    rd_state_t        state;
    rd_state_t        state_next;
    logic [cnt_w-1:0] remaining;
    logic [1:0]       occ;
    logic [width-1:0] head_data;
    logic             head_last;
    logic             accept;
    logic             last_pop;

    assign last_pop = (remaining == cnt_w'(1));
    assign accept   = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (len == '0) ? DONE : READ;
            READ:    if (pop && last_pop) state_next = FLUSH;
            FLUSH:   if (accept && m_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pop is held off during reset so the FIFO keeps its words across a reset.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
        pop  = !rst && (state == READ) && pndng && (remaining != '0) && (occ != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
            rd_count  <= '0;
        end else begin
            if (state == IDLE && start) begin
                remaining <= len;
            end else if (pop) begin
                remaining <= remaining - cnt_w'(1);
            end
            if (pop) begin
                rd_count <= rd_count + cnt_w'(1);
            end
        end
    end

    fifo_reader_skid #(
        .width(width)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (pop),
        .push_data(dato_out),
        .push_last(last_pop),
        .accept   (accept),
        .occ      (occ),
        .head_data(head_data),
        .head_last(head_last)
    );

    assign m_valid = (occ != 2'd0);
    assign m_data  = head_data;
    assign m_last  = m_valid && head_last;

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader driven by a behavioural FWFT FIFO, with a 4-bit counter to exercise wrap.
module tb_fifo_reader;
    import fifo_reader_pkg::*;

    localparam int W  = DEF_WIDTH;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [CW-1:0] len;
    logic          busy;
    logic          done;
    logic          pndng;
    logic [W-1:0]  dato_out;
    logic          pop;
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic          m_last;
    logic          m_ready;
    logic [CW-1:0] rd_count;

    int checks = 0;
    int errors = 0;
    int popCount = 0;
    int beats = 0;

    logic [W-1:0] fifoMem [256];
    int wrPtr = 0;
    int rdPtr = 0;
    logic [W:0] expQ [$];

    fifo_reader #(.width(W), .cnt_w(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .len     (len),
        .busy    (busy),
        .done    (done),
        .pndng   (pndng),
        .dato_out(dato_out),
        .pop     (pop),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_ready (m_ready),
        .rd_count(rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign pndng    = (wrPtr != rdPtr);
    assign dato_out = fifoMem[rdPtr[7:0]];

    always @(posedge clk) begin
        if (pop) rdPtr <= rdPtr + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted beat is compared against the head of the scoreboard.
    always @(negedge clk) begin
        if (pop) popCount++;
        if (!rst && m_valid && m_ready) begin
            beats++;
            if (expQ.size() == 0) begin
                checkOutput("unexpectedBeat", {15'd0, m_data, m_last}, 32'hFFFF_FFFF);
            end else begin
                checkOutput("beatData", {15'd0, m_data, m_last}, {15'd0, expQ.pop_front()});
            end
        end
    end

    task automatic pushWord(input logic [W-1:0] v);
        fifoMem[wrPtr[7:0]] = v;
        wrPtr++;
    endtask

    task automatic expectWord(input logic [W-1:0] v, input logic last);
        expQ.push_back({v, last});
    endtask

    task automatic applyStimulus(input logic [CW-1:0] l);
        @(posedge clk); #1;
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
        len   = '0;
    endtask

    task automatic waitDone(input int maxCycles);
        int seen;
        seen = 0;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        checkOutput("doneSeen", seen, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [5:0] popH, validH, doneH;
        logic [3:0] zDone;
        logic [W-1:0] refData;
        int haveRef, stableErr, p0, zPops;

        rst = 1'b1; start = 1'b0; len = '0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("resetOutputs", {busy, done, pop, m_valid, m_last}, 0);
        checkOutput("resetData", {m_data, 12'd0, rd_count}, 0);

        $display("[TB] basic burst");
        for (int i = 1; i <= 4; i++) pushWord(W'(i));
        for (int i = 1; i <= 4; i++) expectWord(W'(i), i == 4);
        m_ready = 1'b1;
        applyStimulus(4);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            popH[i] = pop; validH[i] = m_valid; doneH[i] = done;
        end
        checkOutput("basicPopRun", popH, 6'b001111);
        checkOutput("basicValidRun", validH, 6'b011110);
        checkOutput("basicDonePulse", doneH, 6'b100000);
        @(negedge clk);
        checkOutput("basicBusyDrop", busy, 0);
        checkOutput("basicCount", rd_count, 4);
        checkOutput("basicFifoEmpty", pndng, 0);

        $display("[TB] backpressure");
        pushWord(16'h0011); pushWord(16'h0022); pushWord(16'h0033);
        expectWord(16'h0011, 0); expectWord(16'h0022, 0); expectWord(16'h0033, 1);
        m_ready = 1'b0;
        applyStimulus(3);
        p0 = popCount; haveRef = 0; stableErr = 0; refData = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_valid) begin
                if (haveRef == 0) begin
                    refData = m_data;
                    haveRef = 1;
                end else if (m_data !== refData) begin
                    stableErr++;
                end
            end
        end
        @(posedge clk); #1;
        checkOutput("stallPops", popCount - p0, 2);
        checkOutput("stallValid", haveRef, 1);
        checkOutput("stallStable", stableErr, 0);
        checkOutput("stallHead", refData, 16'h0011);
        m_ready = 1'b1;
        waitDone(20);
        checkOutput("bpCount", rd_count, 7);

        $display("[TB] starved FIFO");
        pushWord(16'h0101);
        expectWord(16'h0101, 0); expectWord(16'h0202, 0); expectWord(16'h0303, 1);
        applyStimulus(3);
        repeat (8) @(negedge clk);
        checkOutput("starvedState", 32'(dut.state), 32'(READ));
        checkOutput("starvedBusy", {busy, done}, 2'b10);
        @(posedge clk); #1;
        pushWord(16'h0202); pushWord(16'h0303);
        waitDone(20);
        checkOutput("starvedCount", rd_count, 10);

        $display("[TB] zero length");
        @(negedge clk);
        p0 = popCount;
        applyStimulus(0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            zDone[i] = done;
        end
        zPops = popCount - p0;
        checkOutput("zeroLenDone", zDone, 4'b0001);
        checkOutput("zeroLenPops", zPops, 0);

        $display("[TB] ignored start");
        for (int i = 1; i <= 4; i++) pushWord(16'h0500 + W'(i));
        expectWord(16'h0501, 0); expectWord(16'h0502, 1);
        p0 = popCount;
        applyStimulus(2);
        start = 1'b1; len = 4'd5;
        @(posedge clk); #1;
        start = 1'b0; len = '0;
        waitDone(20);
        @(negedge clk);
        checkOutput("ignoredPops", popCount - p0, 2);
        checkOutput("ignoredLeft", wrPtr - rdPtr, 2);
        checkOutput("ignoredIdle", busy, 0);

        $display("[TB] reset mid-burst");
        pushWord(16'h0601); pushWord(16'h0602);
        expectWord(16'h0503, 0); expectWord(16'h0504, 0);
        expectWord(16'h0601, 0); expectWord(16'h0602, 1);
        m_ready = 1'b0;
        applyStimulus(4);
        repeat (4) @(negedge clk);
        checkOutput("occFull", 32'(dut.occ), 2);
        @(posedge clk); #1;
        rst = 1'b1;
        expQ.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstOutputs", {busy, done, pop, m_valid, m_last}, 0);
        checkOutput("rstData", {m_data, 12'd0, rd_count}, 0);
        checkOutput("rstFifoKept", wrPtr - rdPtr, 2);
        m_ready = 1'b1;
        expectWord(16'h0601, 0); expectWord(16'h0602, 1);
        applyStimulus(2);
        waitDone(20);
        checkOutput("postRstCount", rd_count, 2);

        $display("[TB] counter wrap");
        for (int i = 0; i < 15; i++) pushWord(16'h0700 + W'(i));
        for (int i = 0; i < 15; i++) expectWord(16'h0700 + W'(i), i == 14);
        applyStimulus(15);
        waitDone(40);
        checkOutput("wrapCount", rd_count, 1);

        repeat (3) @(negedge clk);
        checkOutput("scoreboardEmpty", expQ.size(), 0);
        checkOutput("totalBeats", beats, 29);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
